// File: rtl/turf_autotrain_pkg.sv
// Shared definitions for the TURF CIN autotrain sequencer.
// Contents: the FSM state enum, the fail-code constants, fixed timing
// constants and the nybble-rotation match helper.
package turf_autotrain_pkg;

  typedef enum logic [4:0] {
    S_IDLE,
    S_RST,
    S_WAIT,
    S_LOAD,
    S_SETTLE,
    S_DWELL,
    S_EVAL,
    S_CENTER,
    S_CLOAD,
    S_ASETTLE,
    S_CAPTURE,
    S_CAPWAIT,
    S_CHECK,
    S_SLIP,
    S_LOCK,
    S_DONE,
    S_FAIL
  } at_state_e;

  localparam logic [1:0] FAIL_NONE  = 2'd0;
  localparam logic [1:0] FAIL_NOEYE = 2'd1;
  localparam logic [1:0] FAIL_SLIP  = 2'd2;
  localparam logic [1:0] FAIL_LOCK  = 2'd3;

  localparam int RST_CYCLES      = 16;
  localparam int CAP_WAIT_CYCLES = 40;

  // True when word equals seq rotated left by any multiple of 4 bits.
  function automatic logic rot_match(input logic [31:0] word, input logic [31:0] seq);
    logic [63:0] dbl;
    logic        hit;
    dbl = {seq, seq};
    hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (dbl[63 - 4 * k -: 32] == word) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/turf_eye_finder.sv
// Clean-run tracker for the IDELAY scan.
// Each eval_i presents one tap result (clean_i) in ascending tap order.
// A clean tap extends the open run; a dirty tap or the last tap closes it.
// A closed run replaces the best only if strictly longer, so on a tie the
// lowest start wins. No wrap-around from the last tap back to tap 0.
// Ports: clk_i/rst_n_i clock and async reset, clear_i restarts tracking,
// eval_i/clean_i/last_i/tap_i tap result, best_start_o/best_width_o result.
module turf_eye_finder
  import turf_autotrain_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clear_i,
  input  logic       eval_i,
  input  logic       clean_i,
  input  logic       last_i,
  input  logic [5:0] tap_i,
  output logic [5:0] best_start_o,
  output logic [6:0] best_width_o
);

  logic [5:0] run_start_q, run_start_d;
  logic [6:0] run_len_q, run_len_d;
  logic [5:0] best_start_q, best_start_d;
  logic [6:0] best_width_q, best_width_d;
  logic [5:0] cand_start_s;
  logic [6:0] cand_len_s;

  // Run/best bookkeeping for one evaluated tap.
  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_width_d = best_width_q;
    // The run start is latched at its first clean tap.
    cand_start_s = (run_len_q == 7'd0) ? tap_i : run_start_q;
    cand_len_s   = clean_i ? (run_len_q + 7'd1) : run_len_q;
    if (clear_i) begin
      run_start_d  = 6'd0;
      run_len_d    = 7'd0;
      best_start_d = 6'd0;
      best_width_d = 7'd0;
    end else if (eval_i) begin
      if (clean_i) begin
        run_start_d = cand_start_s;
        run_len_d   = cand_len_s;
      end else begin
        run_len_d = 7'd0;
      end
      if (!clean_i || last_i) begin
        if (cand_len_s > best_width_q) begin
          best_start_d = cand_start_s;
          best_width_d = cand_len_s;
        end else begin
          best_width_d = best_width_q;
        end
        run_len_d = 7'd0;
      end else begin
        best_width_d = best_width_q;
      end
    end else begin
      run_len_d = run_len_q;
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_start_q  <= 6'd0;
      run_len_q    <= 7'd0;
      best_start_q <= 6'd0;
      best_width_q <= 7'd0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_width_q <= best_width_d;
    end
  end

  assign best_start_o = best_start_q;
  assign best_width_o = best_width_q;

endmodule

// File: rtl/turf_cin_autotrain.sv
// TURF CIN link autotrain sequencer (sysclk domain).
// On start_i: resets the capture path, scans IDELAY taps counting training
// bit errors, loads the centre of the widest clean eye, bitslips the ISERDES
// until the captured word is a nybble rotation of TRAIN_SEQUENCE, then
// requests command lock.
// Ports: sysclk_i/rst_n_i clock and async reset; start_i start request;
// idelay_load_o/idelay_value_o, iserdes_rst_o, iserdes_bitslip_o, sync_rst_o,
// capture_o link controls; capture_data_i/biterr_i/locked_i link status;
// lock_o lock request; busy_o/done_o/fail_o/fail_code_o status;
// eye_start_o/eye_width_o best eye; eye_map_o per-tap clean map.
// Optional macro TURF_AUTOTRAIN_EYEMAP_EN enables the eye map register;
// without it eye_map_o is tied to zero.
module turf_cin_autotrain
  import turf_autotrain_pkg::*;
#(
  parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
  parameter int          NUM_TAPS       = 32,
  parameter int          DWELL_CYCLES   = 1024,
  parameter int          SETTLE_CYCLES  = 16,
  parameter int          MIN_EYE        = 4,
  parameter int          MAX_SLIPS      = 8,
  parameter int          LOCK_TIMEOUT   = 4096
) (
  input  logic        sysclk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  output logic        idelay_load_o,
  output logic [5:0]  idelay_value_o,
  output logic        iserdes_rst_o,
  output logic        iserdes_bitslip_o,
  output logic        sync_rst_o,
  output logic        capture_o,
  input  logic [31:0] capture_data_i,
  input  logic        biterr_i,
  output logic        lock_o,
  input  logic        locked_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [1:0]  fail_code_o,
  output logic [5:0]  eye_start_o,
  output logic [6:0]  eye_width_o,
  output logic [31:0] eye_map_o
);

  at_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  tap_q, tap_d;
  logic [7:0]  slip_q, slip_d;
  logic        err_q, err_d;
  logic [31:0] word_q, word_d;
  logic [5:0]  idv_q, idv_d;
  logic [1:0]  code_q, code_d;
  logic [5:0]  es_q, es_d;
  logic [6:0]  ew_q, ew_d;
  logic        busy_q, done_q, fail_q, lock_q;
  logic        rst_q, load_q, slip_pulse_q, cap_q;
  logic        clear_s, eval_s, last_s;
  logic [5:0]  best_start_s, center_s;
  logic [6:0]  best_width_s;

  assign last_s   = (tap_q == 6'(NUM_TAPS - 1));
  assign center_s = best_start_s + 6'((best_width_s - 7'd1) >> 1);

  turf_eye_finder u_eye (
    .clk_i        (sysclk_i),
    .rst_n_i      (rst_n_i),
    .clear_i      (clear_s),
    .eval_i       (eval_s),
    .clean_i      (!err_q),
    .last_i       (last_s),
    .tap_i        (tap_q),
    .best_start_o (best_start_s),
    .best_width_o (best_width_s)
  );

  // Sequencer next-state logic; cnt_d free-runs and is zeroed on each phase entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    tap_d   = tap_q;
    slip_d  = slip_q;
    err_d   = err_q;
    word_d  = word_q;
    idv_d   = idv_q;
    code_d  = code_q;
    es_d    = es_q;
    ew_d    = ew_q;
    clear_s = 1'b0;
    eval_s  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          state_d = S_RST;
          cnt_d   = 32'd0;
          slip_d  = 8'd0;
          code_d  = FAIL_NONE;
          es_d    = 6'd0;
          ew_d    = 7'd0;
          clear_s = 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RST: begin
        if (cnt_q == 32'(RST_CYCLES - 1)) begin
          state_d = S_WAIT;
          cnt_d   = 32'd0;
        end else begin
          state_d = S_RST;
        end
      end
      S_WAIT: begin
        if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
          state_d = S_LOAD;
          tap_d   = 6'd0;
          idv_d   = 6'd0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_LOAD: begin
        state_d = S_SETTLE;
        cnt_d   = 32'd0;
      end
      S_SETTLE: begin
        if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
          state_d = S_DWELL;
          cnt_d   = 32'd0;
          err_d   = 1'b0;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_DWELL: begin
        err_d = err_q | biterr_i;
        if (cnt_q == 32'(DWELL_CYCLES - 1)) begin
          state_d = S_EVAL;
        end else begin
          state_d = S_DWELL;
        end
      end
      S_EVAL: begin
        eval_s = 1'b1;
        if (last_s) begin
          state_d = S_CENTER;
        end else begin
          state_d = S_LOAD;
          tap_d   = tap_q + 6'd1;
          idv_d   = tap_q + 6'd1;
        end
      end
      S_CENTER: begin
        if (best_width_s < 7'(MIN_EYE)) begin
          state_d = S_FAIL;
          code_d  = FAIL_NOEYE;
        end else begin
          state_d = S_CLOAD;
          es_d    = best_start_s;
          ew_d    = best_width_s;
          idv_d   = center_s;
        end
      end
      S_CLOAD, S_SLIP: begin
        state_d = S_ASETTLE;
        cnt_d   = 32'd0;
      end
      S_ASETTLE: begin
        if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_ASETTLE;
        end
      end
      S_CAPTURE: begin
        state_d = S_CAPWAIT;
        cnt_d   = 32'd0;
      end
      S_CAPWAIT: begin
        if (cnt_q == 32'(CAP_WAIT_CYCLES - 1)) begin
          state_d = S_CHECK;
          word_d  = capture_data_i;
        end else begin
          state_d = S_CAPWAIT;
        end
      end
      S_CHECK: begin
        cnt_d = 32'd0;
        if (rot_match(word_q, TRAIN_SEQUENCE)) begin
          state_d = S_LOCK;
        end else if (slip_q == 8'(MAX_SLIPS)) begin
          state_d = S_FAIL;
          code_d  = FAIL_SLIP;
        end else begin
          state_d = S_SLIP;
          slip_d  = slip_q + 8'd1;
        end
      end
      S_LOCK: begin
        if (locked_i) begin
          state_d = S_DONE;
        end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
          state_d = S_FAIL;
          code_d  = FAIL_LOCK;
        end else begin
          state_d = S_LOCK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      tap_q        <= 6'd0;
      slip_q       <= 8'd0;
      err_q        <= 1'b0;
      word_q       <= 32'd0;
      idv_q        <= 6'd0;
      code_q       <= FAIL_NONE;
      es_q         <= 6'd0;
      ew_q         <= 7'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      lock_q       <= 1'b0;
      rst_q        <= 1'b0;
      load_q       <= 1'b0;
      slip_pulse_q <= 1'b0;
      cap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      slip_q       <= slip_d;
      err_q        <= err_d;
      word_q       <= word_d;
      idv_q        <= idv_d;
      code_q       <= code_d;
      es_q         <= es_d;
      ew_q         <= ew_d;
      busy_q       <= !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_FAIL));
      done_q       <= (state_d == S_DONE);
      fail_q       <= (state_d == S_FAIL);
      lock_q       <= (state_d == S_LOCK) || (state_d == S_DONE);
      rst_q        <= (state_d == S_RST);
      load_q       <= (state_d == S_LOAD) || (state_d == S_CLOAD);
      slip_pulse_q <= (state_d == S_SLIP);
      cap_q        <= (state_d == S_CAPTURE);
    end
  end

`ifdef TURF_AUTOTRAIN_EYEMAP_EN
  logic [31:0] map_q, map_d;

  // Per-tap clean map, cleared on start and filled as each tap is evaluated.
  always_comb begin
    map_d = map_q;
    if (clear_s) begin
      map_d = 32'd0;
    end else if (eval_s && !err_q && (tap_q < 6'd32)) begin
      map_d[tap_q[4:0]] = 1'b1;
    end else begin
      map_d = map_q;
    end
  end

  // Eye map register.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      map_q <= 32'd0;
    end else begin
      map_q <= map_d;
    end
  end

  assign eye_map_o = map_q;
`else
  assign eye_map_o = 32'd0;
`endif

  assign idelay_load_o     = load_q;
  assign idelay_value_o    = idv_q;
  assign iserdes_rst_o     = rst_q;
  assign sync_rst_o        = rst_q;
  assign iserdes_bitslip_o = slip_pulse_q;
  assign capture_o         = cap_q;
  assign lock_o            = lock_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign fail_o            = fail_q;
  assign fail_code_o       = code_q;
  assign eye_start_o       = es_q;
  assign eye_width_o       = ew_q;

endmodule
